// File: rtl/rect_fill_master.sv
// rect_fill_master: paints a constant-colour rectangle into the framebuffer
// as initiator on the memory-adapter bus. Optional feature macro: RECT_FILL_WIDE_EN.
module rect_fill_master #(
    parameter logic [24:0] BASE_ADDR = 25'h0000000,
    parameter int unsigned STRIDE    = 1024
) (
    input  logic        PixelClk2,
    input  logic        RESETn,
    input  logic        Start,
    input  logic [10:0] RectX,
    input  logic [10:0] RectY,
    input  logic [10:0] RectW,
    input  logic [10:0] RectH,
    input  logic [7:0]  Colour,
    output logic        Busy,
    output logic        Done,
    output logic [24:0] Address,
    output logic [31:0] DataWrite,
    output logic [1:0]  DataSize,
    output logic        ReadWrite,
    output logic        Request,
    input  logic        Ready
);

    localparam logic [24:0] STRIDE_A = 25'(STRIDE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_REQ,
        S_GAP,
        S_FIN
    } state_t;

    state_t state, state_nxt;

    logic [10:0] x_q, y_q, w_q;
    logic [10:0] rem_q, rows_q;
    logic [24:0] row_base_q, addr_q;
    logic [7:0]  colour_q;

    logic        word_beat;
    logic [10:0] step;
    logic [10:0] rem_nxt;
    logic        row_end;
    logic        last_beat;
    logic [24:0] setup_base;

`ifdef RECT_FILL_WIDE_EN
    assign word_beat = (addr_q[1:0] == 2'b00) && (rem_q >= 11'd4);
`else
    assign word_beat = 1'b0;
`endif

    assign step       = word_beat ? 11'd4 : 11'd1;
    assign rem_nxt    = rem_q - step;
    assign row_end    = (rem_nxt == 11'd0);
    assign last_beat  = row_end && (rows_q == 11'd1);
    assign setup_base = BASE_ADDR + 25'(y_q) * STRIDE_A;

    assign Address   = addr_q;
    assign DataWrite = {4{colour_q}};
    assign ReadWrite = 1'b0;

    // State register; reset drops Request immediately via the state.
    always_ff @(posedge PixelClk2 or negedge RESETn) begin
        if (!RESETn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state: one Ready per request, then a low gap or completion.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (Start) state_nxt = S_SETUP;
            S_SETUP: begin
                if (w_q == 11'd0 || rows_q == 11'd0) state_nxt = S_FIN;
                else                                 state_nxt = S_REQ;
            end
            S_REQ: begin
                if (Ready) state_nxt = last_beat ? S_FIN : S_GAP;
            end
            S_GAP:   state_nxt = S_REQ;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus handshake and status outputs decoded from state.
    always_comb begin
        Busy     = 1'b0;
        Done     = 1'b0;
        Request  = 1'b0;
        DataSize = 2'b00;
        unique case (state)
            S_SETUP, S_GAP: Busy = 1'b1;
            S_REQ: begin
                Busy     = 1'b1;
                Request  = 1'b1;
                DataSize = word_beat ? 2'b10 : 2'b00;
            end
            S_FIN:   Done = 1'b1;
            default: ;
        endcase
    end

    // Rectangle latch and address walk; advances only on an accepted beat.
    always_ff @(posedge PixelClk2 or negedge RESETn) begin
        if (!RESETn) begin
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= '0;
            rem_q      <= '0;
            rows_q     <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            colour_q   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (Start) begin
                        x_q      <= RectX;
                        y_q      <= RectY;
                        w_q      <= RectW;
                        rem_q    <= RectW;
                        rows_q   <= RectH;
                        colour_q <= Colour;
                    end
                end
                S_SETUP: begin
                    row_base_q <= setup_base;
                    addr_q     <= setup_base + 25'(x_q);
                end
                S_REQ: begin
                    if (Ready) begin
                        if (row_end) begin
                            rows_q     <= rows_q - 11'd1;
                            row_base_q <= row_base_q + STRIDE_A;
                            addr_q     <= row_base_q + STRIDE_A + 25'(x_q);
                            rem_q      <= w_q;
                        end else begin
                            addr_q <= addr_q + 25'(step);
                            rem_q  <= rem_nxt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
